// File: rtl/rom_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rom_reader_pkg
// Purpose  : Shared constants and types for the 556PT5 (3604) / 556PT4 (3601)
//            PROM reader path: chip identifiers, bus widths, control-line
//            encodings and the address-sweep state type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rom_reader_pkg;

  // Chip type identifiers
  localparam int IP3604 = 1;
  localparam int IP3601 = 2;

  // Bus widths per chip type
  localparam int IP3604_DATA_WIDTH = 8;
  localparam int IP3601_DATA_WIDTH = 4;
  localparam int IP3604_ADDR_WIDTH = 9;
  localparam int IP3601_ADDR_WIDTH = 8;

  // Control lines V1..V4, bit0 = V1
  localparam logic [3:0] OP_IDLE = 4'b0000;
  localparam logic [3:0] OP_READ = 4'b1100;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SETTLE     = 2'd1,
    WAIT_READY = 2'd2,
    DONE       = 2'd3
  } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/settle_timer.sv
`default_nettype none
// ============================================================================
// Module   : settle_timer
// Purpose  : 8-bit loadable down-counter that times the PROM settle interval.
//            The count stops at zero; zero is flagged from the register.
// Ports    : clk        - system clock
//            reset_n    - synchronous active-low reset (count cleared)
//            load       - load load_value this edge (wins over decrement)
//            load_value - value to load
//            zero       - count is zero
// Revision : 1.0 - initial release
// ============================================================================
module settle_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic       zero
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != 8'd0) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == 8'd0);

endmodule
`default_nettype wire

// File: rtl/rom_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rom_scan_sequencer
// Purpose  : Automatic full-chip address sweep for the PROM reader. Drives
//            address and read-control lines, waits a settle time after each
//            address change, samples the data bus and streams {address, data}
//            words downstream on a valid/ready interface.
// Ports    : clk, reset_n    - clock, synchronous active-low reset
//            start, abort    - begin sweep (IDLE only) / stop sweep
//            data_line_in    - PROM data bus
//            operation       - control lines V1..V4 (bit0 = V1)
//            address_line    - PROM address
//            out_valid/ready - output stream handshake
//            out_address     - address of the sampled word
//            out_data        - sampled data
//            out_last        - word belongs to the final (all-ones) address
//            busy            - sequencer is not idle
//            done            - one-cycle pulse on normal sweep completion
// Revision : 1.0 - initial release
// ============================================================================
module rom_scan_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 9,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [DATA_WIDTH-1:0]    data_line_in,
  output logic [3:0]               operation,
  output logic [ADDRESS_WIDTH-1:0] address_line,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH-1:0] out_address,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  import rom_reader_pkg::*;

  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 255)) begin : g_settle_range_check
    $error("rom_scan_sequencer: SETTLE_CYCLES must be in 1..255");
  end

  // The counter is loaded one cycle before SETTLE is entered, so the sample
  // lands SETTLE_CYCLES edges after the address change.
  localparam logic [7:0] c_settle_load = 8'(SETTLE_CYCLES - 1);
  localparam logic [ADDRESS_WIDTH-1:0] c_addr_one = ADDRESS_WIDTH'(1);

  scan_state_e              state_q,     state_d;
  logic [3:0]               op_q,        op_d;
  logic [ADDRESS_WIDTH-1:0] address_q,   address_d;
  logic                     valid_q,     valid_d;
  logic [ADDRESS_WIDTH-1:0] out_addr_q,  out_addr_d;
  logic [DATA_WIDTH-1:0]    out_data_q,  out_data_d;
  logic                     last_q,      last_d;
  logic                     busy_q,      busy_d;
  logic                     done_q,      done_d;
  logic                     timer_load;
  logic                     timer_zero;

  settle_timer u_settle_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load),
    .load_value (c_settle_load),
    .zero       (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    address_d  = address_q;
    valid_d    = valid_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    last_d     = last_q;
    timer_load = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          address_d  = '0;
          op_d       = OP_READ;
          timer_load = 1'b1;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (timer_zero) begin
          out_data_d = data_line_in;
          out_addr_d = address_q;
          last_d     = &address_q;
          valid_d    = 1'b1;
          state_d    = WAIT_READY;
        end
      end
      WAIT_READY: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            op_d    = OP_IDLE;
            state_d = DONE;
          end else begin
            address_d  = address_q + c_addr_one;
            timer_load = 1'b1;
            state_d    = SETTLE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort from any active state discards the pending word and parks the chip.
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      valid_d    = 1'b0;
      op_d       = OP_IDLE;
      address_d  = '0;
      timer_load = 1'b0;
    end

    // Status flags are registered from the next state so they align with it.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      op_q       <= OP_IDLE;
      address_q  <= '0;
      valid_q    <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      address_q  <= address_d;
      valid_q    <= valid_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign operation    = op_q;
  assign address_line = address_q;
  assign out_valid    = valid_q;
  assign out_address  = out_addr_q;
  assign out_data     = out_data_q;
  assign out_last     = last_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_scan_sequencer
// Purpose  : Self-checking bench for rom_scan_sequencer. Two instances: a
//            small 8-word configuration (A) and a 3601-style 256-word one (B).
//            A PROM model table feeds each data bus; expected words come from
//            that table and the sweep rules (address order, settle latency,
//            last flag, done pulse).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_scan_sequencer;

  localparam int DW_A = 8, AW_A = 3, ST_A = 4;
  localparam int DW_B = 4, AW_B = 8, ST_B = 1;
  localparam int BUDGET = 300;

  localparam int F_VALID = 0, F_ADDR = 1, F_DATA = 2, F_LAST = 3;
  localparam int F_BUSY = 4, F_DONE = 5, F_OP = 6, F_ALINE = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n_a, reset_n_b, start, abort, out_ready;
  logic [7:0] tbl [0:255];

  logic [DW_A-1:0] data_a, odata_a;
  logic [AW_A-1:0] aline_a, oaddr_a;
  logic [3:0]      op_a;
  logic            valid_a, last_a, busy_a, done_a;

  logic [DW_B-1:0] data_b, odata_b;
  logic [AW_B-1:0] aline_b, oaddr_b;
  logic [3:0]      op_b;
  logic            valid_b, last_b, busy_b, done_b;

  // PROM models: data bus follows the addressed table entry
  assign data_a = tbl[aline_a];
  assign data_b = tbl[aline_b][3:0];

  rom_scan_sequencer #(.DATA_WIDTH(DW_A), .ADDRESS_WIDTH(AW_A), .SETTLE_CYCLES(ST_A)) u_dut_a (
    .clk(clk), .reset_n(reset_n_a), .start(start), .abort(abort),
    .data_line_in(data_a), .operation(op_a), .address_line(aline_a),
    .out_valid(valid_a), .out_ready(out_ready), .out_address(oaddr_a),
    .out_data(odata_a), .out_last(last_a), .busy(busy_a), .done(done_a)
  );

  rom_scan_sequencer #(.DATA_WIDTH(DW_B), .ADDRESS_WIDTH(AW_B), .SETTLE_CYCLES(ST_B)) u_dut_b (
    .clk(clk), .reset_n(reset_n_b), .start(start), .abort(abort),
    .data_line_in(data_b), .operation(op_b), .address_line(aline_b),
    .out_valid(valid_b), .out_ready(out_ready), .out_address(oaddr_b),
    .out_data(odata_b), .out_last(last_b), .busy(busy_b), .done(done_b)
  );

  int tests = 0;
  int fails = 0;
  int sel   = 0;   // 0 = instance A, 1 = instance B

  function automatic logic [31:0] rd(input int f);
    logic [31:0] v;
    v = '0;
    case (f)
      F_VALID: v = (sel != 0) ? 32'(valid_b) : 32'(valid_a);
      F_ADDR:  v = (sel != 0) ? 32'(oaddr_b) : 32'(oaddr_a);
      F_DATA:  v = (sel != 0) ? 32'(odata_b) : 32'(odata_a);
      F_LAST:  v = (sel != 0) ? 32'(last_b)  : 32'(last_a);
      F_BUSY:  v = (sel != 0) ? 32'(busy_b)  : 32'(busy_a);
      F_DONE:  v = (sel != 0) ? 32'(done_b)  : 32'(done_a);
      F_OP:    v = (sel != 0) ? 32'(op_b)    : 32'(op_a);
      F_ALINE: v = (sel != 0) ? 32'(aline_b) : 32'(aline_a);
      default: v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] exp_data(input int idx);
    return (sel != 0) ? {28'd0, tbl[idx][3:0]} : {24'd0, tbl[idx]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, rd(F_VALID), 0);
    check({tag, "_addr"},  rd(F_ADDR),  0);
    check({tag, "_data"},  rd(F_DATA),  0);
    check({tag, "_last"},  rd(F_LAST),  0);
    check({tag, "_busy"},  rd(F_BUSY),  0);
    check({tag, "_done"},  rd(F_DONE),  0);
    check({tag, "_op"},    rd(F_OP),    0);
    check({tag, "_aline"}, rd(F_ALINE), 0);
  endtask

  // One full sweep against the model. max_hold>0 withholds ready for a random
  // 1..max_hold cycles per word. abort_addr / restart_addr / reset_addr (-1 =
  // unused) inject abort in SETTLE, a stray start in SETTLE, or a reset in
  // WAIT_READY at that address.
  task automatic sweep(input int max_hold, input int abort_addr,
                       input int restart_addr, input int reset_addr);
    int n_words, settle, lat, pre, hold, seen;
    n_words   = (sel != 0) ? 256 : 8;
    settle    = (sel != 0) ? ST_B : ST_A;
    out_ready = (max_hold == 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy",  rd(F_BUSY),  1);
    check("start_op",    rd(F_OP),    32'b1100);
    check("start_aline", rd(F_ALINE), 0);
    check("start_valid", rd(F_VALID), 0);
    pre = 0;
    for (int idx = 0; idx < n_words; idx++) begin
      lat = pre;
      pre = 0;
      while ((rd(F_VALID) !== 1) && (lat < BUDGET)) begin
        tick();
        lat++;
      end
      check("latency", lat, settle);
      if (lat >= BUDGET) begin
        out_ready = 1'b0;
        return;
      end
      check("word_addr",  rd(F_ADDR),  idx);
      check("word_data",  rd(F_DATA),  exp_data(idx));
      check("word_last",  rd(F_LAST),  (idx == n_words - 1) ? 1 : 0);
      check("word_aline", rd(F_ALINE), idx);
      check("word_op",    rd(F_OP),    32'b1100);
      check("word_busy",  rd(F_BUSY),  1);
      if (idx == reset_addr) begin
        out_ready = 1'b0;
        if (sel != 0) reset_n_b = 1'b0; else reset_n_a = 1'b0;
        tick();
        if (sel != 0) reset_n_b = 1'b1; else reset_n_a = 1'b1;
        check_reset_state("midrst");
        out_ready = 1'b1;
        seen = 0;
        repeat (40) begin
          tick();
          if ((rd(F_VALID) !== 0) || (rd(F_BUSY) !== 0)) seen = 1;
        end
        check("midrst_quiet", seen, 0);
        out_ready = 1'b0;
        return;
      end
      hold = (max_hold > 0) ? int'($urandom_range(max_hold, 1)) : 0;
      out_ready = 1'b0;
      repeat (hold) begin
        tick();
        check("hold_valid", rd(F_VALID), 1);
        check("hold_addr",  rd(F_ADDR),  idx);
        check("hold_data",  rd(F_DATA),  exp_data(idx));
        check("hold_aline", rd(F_ALINE), idx);
      end
      out_ready = 1'b1;
      tick();
      out_ready = (max_hold == 0);
      check("hs_valid", rd(F_VALID), 0);
      if (idx == n_words - 1) begin
        check("done_pulse", rd(F_DONE), 1);
        check("done_busy",  rd(F_BUSY), 1);
        check("done_op",    rd(F_OP),   0);
        tick();
        check("after_done",  rd(F_DONE), 0);
        check("after_busy",  rd(F_BUSY), 0);
        check("after_op",    rd(F_OP),   0);
      end else begin
        check("next_aline", rd(F_ALINE), idx + 1);
        check("next_done",  rd(F_DONE),  0);
        if (idx + 1 == abort_addr) begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
          check("abort_busy",  rd(F_BUSY),  0);
          check("abort_valid", rd(F_VALID), 0);
          check("abort_op",    rd(F_OP),    0);
          check("abort_aline", rd(F_ALINE), 0);
          seen = 0;
          repeat (20) begin
            if (rd(F_DONE) !== 0) seen = 1;
            tick();
          end
          check("abort_no_done", seen, 0);
          out_ready = 1'b0;
          return;
        end
        if (idx + 1 == restart_addr) begin
          start = 1'b1;
          tick();
          start = 1'b0;
          pre = 1;
          check("restart_ignored", rd(F_ALINE), idx + 1);
          check("restart_busy",    rd(F_BUSY),  1);
        end
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    reset_n_a = 1'b0; reset_n_b = 1'b0;
    for (int i = 0; i < 256; i++) tbl[i] = 8'(i ^ 8'hA5);
    repeat (3) tick();
    sel = 0; check_reset_state("rst_a");
    sel = 1; check_reset_state("rst_b");

    // Instance A: 8 words, settle 4
    sel = 0;
    reset_n_a = 1'b1;
    tick();
    sweep(0, -1, -1, -1);                 // ready always high
    repeat (3) tick();
    sweep(3, -1, -1, -1);                 // ready withheld each word
    for (int i = 0; i < 256; i++) tbl[i] = 8'($urandom);
    sweep(3, -1, -1, -1);                 // random PROM contents
    for (int i = 0; i < 256; i++) tbl[i] = 8'(i ^ 8'hA5);
    sweep(0, 3, -1, -1);                  // abort at address 3
    sweep(0, -1, -1, -1);                 // clean restart from 0
    sweep(0, -1, 2, -1);                  // stray start at address 2

    start = 1'b1; abort = 1'b1;           // start with abort in IDLE
    tick();
    start = 1'b0; abort = 1'b0;
    check("sa_busy", rd(F_BUSY), 0);
    check("sa_op",   rd(F_OP),   0);
    tick();
    check("sa_busy2", rd(F_BUSY), 0);

    sweep(0, -1, -1, 5);                  // reset in WAIT_READY at address 5
    sweep(0, -1, -1, -1);                 // recovery after reset

    // Instance B: 3601 geometry, 256 words, settle 1
    reset_n_a = 1'b0;
    sel = 1;
    reset_n_b = 1'b1;
    for (int i = 0; i < 256; i++) tbl[i] = 8'(i);
    tick();
    sweep(0, -1, -1, -1);
    for (int i = 0; i < 256; i++) tbl[i] = 8'($urandom);
    sweep(2, -1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
